// File: rtl/uart_pkg.sv
// Types and constants shared by the UART receive path.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO whose head word is registered and valid whenever it is non-empty.
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  push,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  pop,
  output logic [WIDTH-1:0]      rdata,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [DEPTH_LOG2:0]   count_next
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_r;
  logic [DEPTH_LOG2-1:0] rd_ptr_next_s;
  logic [DEPTH_LOG2:0]   count_r;
  logic [WIDTH-1:0]      rdata_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  assign full  = (count_r == FULL_COUNT);
  assign empty = (count_r == {(DEPTH_LOG2+1){1'b0}});

  // A pop frees the head slot first, so a push into a full FIFO is legal in the same cycle.
  assign pop_ok_s      = pop && !empty;
  assign push_ok_s     = push && (!full || pop_ok_s);
  assign rd_ptr_next_s = pop_ok_s ? (rd_ptr_r + 1'b1) : rd_ptr_r;

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    count_next = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_next = count_r + 1'b1;
    end else if (pop_ok_s && !push_ok_s) begin
      count_next = count_r - 1'b1;
    end else begin
      count_next = count_r;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and registered head (bypassing a write that lands on the new head).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {(DEPTH_LOG2+1){1'b0}};
      rdata_r  <= {WIDTH{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      rd_ptr_r <= rd_ptr_next_s;
      count_r  <= count_next;
      rdata_r  <= (push_ok_s && (wr_ptr_r == rd_ptr_next_s)) ? wdata : mem_r[rd_ptr_next_s];
    end
  end

  assign rdata = rdata_r;
  assign count = count_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with oversampling deframer, receive FIFO and RTS flow control.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int DEPTH_LOG2   = 4,
  parameter int RTS_MARGIN   = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  uart_rx,
  output logic                  uart_rts,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  frame_err,
  output logic                  overrun
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int MID_I  = CLKS_PER_BIT / 2 - 1;
  localparam int LAST_I = CLKS_PER_BIT - 1;
  localparam int THR_I  = (1 << DEPTH_LOG2) - RTS_MARGIN;
  localparam int LIDX_I = UART_DATA_BITS - 1;

  localparam logic [CW-1:0]       MID_CNT  = MID_I[CW-1:0];
  localparam logic [CW-1:0]       LAST_CNT = LAST_I[CW-1:0];
  localparam logic [DEPTH_LOG2:0] RTS_THR  = THR_I[DEPTH_LOG2:0];
  localparam logic [2:0]          LAST_IDX = LIDX_I[2:0];

  logic [1:0]          sync_r;
  logic                rx_s;
  rx_state_t           state_r;
  logic [CW-1:0]       cnt_r;
  logic [2:0]          idx_r;
  uart_byte_t          shift_r;
  logic                frame_err_r;
  logic                overrun_r;
  logic                rts_r;
  logic                stop_tick_s;
  logic                pop_s;
  logic                push_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [DEPTH_LOG2:0] count_s;
  logic [DEPTH_LOG2:0] count_next_s;
  uart_byte_t          head_s;

  // Two-flop synchronizer, preset to the idle line level.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], uart_rx};
    end
  end

  assign rx_s = sync_r[1];

  assign stop_tick_s = (state_r == STOP) && (cnt_r == LAST_CNT);
  assign pop_s       = rx_ready && !fifo_empty_s;
  assign push_s      = stop_tick_s && rx_s && (!fifo_full_s || pop_s);

  // Deframer: start-bit qualification at mid-bit, then one sample per bit period.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r     <= IDLE;
      cnt_r       <= {CW{1'b0}};
      idx_r       <= 3'd0;
      shift_r     <= 8'h00;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          cnt_r <= {CW{1'b0}};
          if (!rx_s) begin
            state_r <= START;
          end
        end
        START: begin
          if (cnt_r == MID_CNT) begin
            cnt_r   <= {CW{1'b0}};
            idx_r   <= 3'd0;
            state_r <= rx_s ? IDLE : DATA;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        DATA: begin
          if (cnt_r == LAST_CNT) begin
            cnt_r   <= {CW{1'b0}};
            shift_r <= {rx_s, shift_r[UART_DATA_BITS-1:1]};
            idx_r   <= idx_r + 3'd1;
            if (idx_r == LAST_IDX) begin
              state_r <= STOP;
            end
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        STOP: begin
          if (stop_tick_s) begin
            cnt_r       <= {CW{1'b0}};
            state_r     <= IDLE;
            frame_err_r <= !rx_s;
            overrun_r   <= rx_s && !push_s;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
        end
      endcase
    end
  end

  // RTS follows next-cycle occupancy so it tracks the FIFO without lag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rts_r <= 1'b1;
    end else begin
      rts_r <= (count_next_s > RTS_THR);
    end
  end

  sync_fifo #(
    .WIDTH      (UART_DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push_s),
    .wdata      (shift_r),
    .pop        (pop_s),
    .rdata      (head_s),
    .full       (fifo_full_s),
    .empty      (fifo_empty_s),
    .count      (count_s),
    .count_next (count_next_s)
  );

  assign uart_rts  = rts_r;
  assign rx_data   = head_s;
  assign rx_valid  = !fifo_empty_s;
  assign rx_count  = count_s;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames in, scoreboard of expected bytes checked on every pop.
module tb_uart_rx_fifo;

  localparam int CPB = 8;
  localparam int DL2 = 2;
  localparam int MARGIN = 1;

  logic           clk = 1'b0;
  logic           resetn;
  logic           uart_rx;
  logic           uart_rts;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_ready;
  logic [DL2:0]   rx_count;
  logic           frame_err;
  logic           overrun;

  int total = 0;
  int bad = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe0;
  int ov0;
  logic [7:0] exp_q[$];

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH_LOG2   (DL2),
    .RTS_MARGIN   (MARGIN)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .uart_rx   (uart_rx),
    .uart_rts  (uart_rts),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse counters and scoreboard pop, sampled mid-cycle.
  always @(negedge clk) begin
    if (resetn) begin
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          assert (exp_q.size() != 0) else begin
            bad++;
            $error("FAIL pop_unexpected observed=%0h expected=none", rx_data);
          end
        end else begin
          chk("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic pop_at_stop);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      uart_rx = frame[i];
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = stop_bit;
    if (pop_at_stop) begin
      repeat (CPB - 2) @(posedge clk);
      #1;
      rx_ready = 1'b1;
      @(posedge clk);
      #1;
      rx_ready = 1'b0;
      @(posedge clk);
      #1;
    end else begin
      repeat (CPB) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
  endtask

  task automatic pulse_pop();
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_ready = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] b;
    resetn = 1'b0;
    uart_rx = 1'b1;
    rx_ready = 1'b0;
    #12;
    chk("rst_rts", 32'(uart_rts), 32'd1);
    chk("rst_valid", 32'(rx_valid), 32'd0);
    chk("rst_count", 32'(rx_count), 32'd0);
    chk("rst_data", 32'(rx_data), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rts_after_release", 32'(uart_rts), 32'd0);

    // one byte held, then reset in the middle of the next frame
    exp_q.push_back(8'h5A);
    send_byte(8'h5A, 1'b1, 1'b0);
    chk("pre_rst_count", 32'(rx_count), 32'd1);
    chk("pre_rst_data", 32'(rx_data), 32'(exp_q[0]));
    uart_rx = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("async_rst_rts", 32'(uart_rts), 32'd1);
    chk("async_rst_valid", 32'(rx_valid), 32'd0);
    chk("async_rst_count", 32'(rx_count), 32'd0);
    chk("async_rst_data", 32'(rx_data), 32'd0);
    exp_q.delete();
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    chk("rts_after_rerelease", 32'(uart_rts), 32'd0);
    repeat (120) @(posedge clk);
    #1;
    chk("partial_ignored_count", 32'(rx_count), 32'd0);

    // single byte
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, 1'b1, 1'b0);
    chk("single_valid", 32'(rx_valid), 32'd1);
    chk("single_count", 32'(rx_count), 32'd1);
    chk("single_data", 32'(rx_data), 32'(exp_q[0]));
    pulse_pop();
    chk("single_drained", 32'(rx_count), 32'd0);

    // glitch and framing error
    fe0 = fe_cnt;
    uart_rx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    uart_rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("glitch_count", 32'(rx_count), 32'd0);
    chk("glitch_no_fe", 32'(fe_cnt), 32'(fe0));
    send_byte(8'h3C, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("frame_err_pulse", 32'(fe_cnt), 32'(fe0 + 1));
    chk("frame_err_count", 32'(rx_count), 32'd0);

    // fill, RTS and overrun
    for (int i = 1; i <= 4; i++) begin
      b = 8'(i);
      exp_q.push_back(b);
      send_byte(b, 1'b1, 1'b0);
      if (i == 3) begin
        chk("rts_at_3", 32'(uart_rts), 32'd0);
        chk("count_at_3", 32'(rx_count), 32'd3);
      end
    end
    chk("rts_at_4", 32'(uart_rts), 32'd1);
    chk("count_at_4", 32'(rx_count), 32'd4);
    ov0 = ov_cnt;
    send_byte(8'h05, 1'b1, 1'b0);
    chk("overrun_pulse", 32'(ov_cnt), 32'(ov0 + 1));
    chk("overrun_count", 32'(rx_count), 32'd4);
    chk("overrun_head", 32'(rx_data), 32'(exp_q[0]));

    // simultaneous push and pop when full
    ov0 = ov_cnt;
    exp_q.push_back(8'h06);
    send_byte(8'h06, 1'b1, 1'b1);
    chk("simul_no_overrun", 32'(ov_cnt), 32'(ov0));
    chk("simul_count", 32'(rx_count), 32'd4);
    chk("simul_head", 32'(rx_data), 32'(exp_q[0]));
    repeat (4) pulse_pop();
    chk("drain_count", 32'(rx_count), 32'd0);
    chk("drain_rts", 32'(uart_rts), 32'd0);
    chk("drain_sb_empty", 32'(exp_q.size()), 32'd0);

    // back-to-back frames with consumer always ready
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    rx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b1, 1'b0);
      chk("b2b_rts", 32'(uart_rts), 32'd0);
    end
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("b2b_all_delivered", 32'(exp_q.size()), 32'd0);
    chk("b2b_no_fe", 32'(fe_cnt), 32'(fe0));
    chk("b2b_no_ov", 32'(ov_cnt), 32'(ov0));
    chk("b2b_count", 32'(rx_count), 32'd0);
    rx_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
